// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM microphone receiver.
//   CIC_ORDER       : number of integrator/comb stages
//   CIC_DIFF_DELAY  : comb differential delay
//   PCM_WIDTH       : width of the presented PCM samples
//   DEF_CLKDIV      : default ock half-period in clk cycles
//   DEF_DECIM       : default decimation ratio in ock periods
package pdm_pkg;

    localparam int CIC_ORDER      = 3;
    localparam int CIC_DIFF_DELAY = 1;
    localparam int PCM_WIDTH      = 32;
    localparam int DEF_CLKDIV     = 4;
    localparam int DEF_DECIM      = 64;

    // ock phase sequencer states
    typedef enum logic [1:0] {
        OCK_IDLE = 2'd0,
        OCK_HIGH = 2'd1,
        OCK_LOW  = 2'd2
    } ock_state_t;

    // Datapath width for a +/-1 input: order*log2(R) growth plus sign/headroom.
    function automatic int cic_width(input int decim);
        return CIC_ORDER * $clog2(decim) + 2;
    endfunction

endpackage

// File: rtl/pdm_cic_decim.sv
// Single-channel CIC decimator for a 1-bit PDM stream.
//   clk, rstn : system clock, async active-low reset
//   clr       : synchronous clear of all filter state
//   in_bit    : PDM bit, 1 -> +1, 0 -> -1
//   in_stb    : one-cycle strobe, integrators advance by one input sample
//   out_stb   : one-cycle strobe, dout holds a new decimated sample
//   dout      : signed decimated output (valid while out_stb=1)
module pdm_cic_decim
    import pdm_pkg::*;
#(
    parameter int DECIM = DEF_DECIM,
    parameter int W     = cic_width(DEF_DECIM)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                in_bit,
    input  logic                in_stb,
    output logic                out_stb,
    output logic signed [W-1:0] dout
);

    localparam int DW = $clog2(DECIM);
    localparam logic [DW-1:0] DEC_LOAD = DW'(DECIM - 1);

    logic signed [W-1:0] x;
    logic signed [W-1:0] integ     [CIC_ORDER];
    logic signed [W-1:0] integ_nxt [CIC_ORDER];
    logic signed [W-1:0] comb_in   [CIC_ORDER];
    logic signed [W-1:0] comb_dly  [CIC_ORDER][CIC_DIFF_DELAY];
    logic signed [W-1:0] iacc;
    logic signed [W-1:0] cacc;
    logic [DW-1:0]       dec_cnt;
    logic                pend;

    assign x = in_bit ? W'(1) : '1;

    // Integrators chain combinationally so a cascade of N stages adds no
    // extra sample delay; wrap-around is harmless because the comb result
    // always fits in W bits.
    always_comb begin
        iacc = x;
        for (int i = 0; i < CIC_ORDER; i++) begin
            iacc         = integ[i] + iacc;
            integ_nxt[i] = iacc;
        end
    end

    always_comb begin
        cacc = integ[CIC_ORDER-1];
        for (int i = 0; i < CIC_ORDER; i++) begin
            comb_in[i] = cacc;
            cacc       = cacc - comb_dly[i][CIC_DIFF_DELAY-1];
        end
        dout = cacc;
    end

    assign out_stb = pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_cnt <= DEC_LOAD;
            pend    <= 1'b0;
            for (int i = 0; i < CIC_ORDER; i++) begin
                integ[i] <= '0;
                for (int j = 0; j < CIC_DIFF_DELAY; j++) comb_dly[i][j] <= '0;
            end
        end else if (clr) begin
            dec_cnt <= DEC_LOAD;
            pend    <= 1'b0;
            for (int i = 0; i < CIC_ORDER; i++) begin
                integ[i] <= '0;
                for (int j = 0; j < CIC_DIFF_DELAY; j++) comb_dly[i][j] <= '0;
            end
        end else begin
            pend <= in_stb && (dec_cnt == '0);
            if (in_stb) begin
                for (int i = 0; i < CIC_ORDER; i++) integ[i] <= integ_nxt[i];
                dec_cnt <= (dec_cnt == '0) ? DEC_LOAD : dec_cnt - 1'b1;
            end
            // Combs run one clk after the last integrator update of the period.
            if (pend) begin
                for (int i = 0; i < CIC_ORDER; i++) begin
                    comb_dly[i][0] <= comb_in[i];
                    for (int j = 1; j < CIC_DIFF_DELAY; j++) comb_dly[i][j] <= comb_dly[i][j-1];
                end
            end
        end
    end

endmodule

// File: rtl/pdm_mic_rx.sv
// Stereo PDM microphone receiver: generates the PDM bit clock, splits the
// shared data line into left (ock high) and right (ock low) bits, decimates
// each with a CIC filter and presents sample pairs with valid/ready.
//   clk, rstn      : system clock, async active-low reset
//   en             : link enable
//   ock            : PDM bit clock to the microphones
//   sdi            : shared stereo PDM data
//   dout_l, dout_r : PCM sample pair, two's complement
//   valid, ready   : sample-pair handshake
//   ovf, clr_ovf   : sticky overflow flag (pair dropped) and its clear
//
// ock sequencer
//   state    | meaning
//   OCK_IDLE | ock low before the first rising edge (or link disabled)
//   OCK_HIGH | ock high, left bit sampled on the last cycle
//   OCK_LOW  | ock low, right bit sampled on the last cycle
module pdm_mic_rx
    import pdm_pkg::*;
#(
    parameter int CLKDIV = DEF_CLKDIV,
    parameter int DECIM  = DEF_DECIM
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    output logic                 ock,
    input  logic                 sdi,
    output logic [PCM_WIDTH-1:0] dout_l,
    output logic [PCM_WIDTH-1:0] dout_r,
    output logic                 valid,
    input  logic                 ready,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam int CW   = cic_width(DECIM);
    localparam int DIVW = $clog2(CLKDIV);
    localparam int SW   = $clog2(CIC_ORDER + 1);
    localparam logic [DIVW-1:0] DIV_LOAD = DIVW'(CLKDIV - 1);

    ock_state_t          state, state_nxt;
    logic [DIVW-1:0]     div;
    logic                tc;
    logic                left_stb, right_stb;
    logic                left_bit;
    logic                stb_l, stb_r, dec_stb;
    logic signed [CW-1:0] y_l, y_r;
    logic [SW-1:0]       settle;
    logic                present;

    assign tc = (div == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= OCK_IDLE;
            div   <= DIV_LOAD;
        end else begin
            state <= state_nxt;
            if (!en || tc) div <= DIV_LOAD;
            else           div <= div - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        left_stb  = 1'b0;
        right_stb = 1'b0;
        if (!en) begin
            state_nxt = OCK_IDLE;
        end else if (tc) begin
            case (state)
                OCK_IDLE: state_nxt = OCK_HIGH;
                OCK_HIGH: begin
                    state_nxt = OCK_LOW;
                    left_stb  = 1'b1;
                end
                OCK_LOW: begin
                    state_nxt = OCK_HIGH;
                    right_stb = 1'b1;
                end
                default: state_nxt = OCK_IDLE;
            endcase
        end
    end

    // Gated by en so the clock stops in the same cycle the link is disabled.
    assign ock = en && (state == OCK_HIGH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         left_bit <= 1'b0;
        else if (left_stb) left_bit <= sdi;
    end

    // Both filters advance on the right-bit strobe so the pair completes together.
    pdm_cic_decim #(.DECIM(DECIM), .W(CW)) u_cic_l (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (!en),
        .in_bit  (left_bit),
        .in_stb  (right_stb),
        .out_stb (stb_l),
        .dout    (y_l)
    );

    pdm_cic_decim #(.DECIM(DECIM), .W(CW)) u_cic_r (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (!en),
        .in_bit  (sdi),
        .in_stb  (right_stb),
        .out_stb (stb_r),
        .dout    (y_r)
    );

    assign dec_stb = stb_l && stb_r;
    assign present = dec_stb && (settle == SW'(CIC_ORDER));

    // The first CIC_ORDER outputs after enable still see the zero start-up state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                         settle <= '0;
        else if (!en)                                      settle <= '0;
        else if (dec_stb && (settle != SW'(CIC_ORDER)))    settle <= settle + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_l <= '0;
            dout_r <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (present && (!valid || ready)) begin
                dout_l <= PCM_WIDTH'(y_l);
                dout_r <= PCM_WIDTH'(y_r);
                valid  <= 1'b1;
            end else if (valid && ready) begin
                valid  <= 1'b0;
            end
            if (present && valid && !ready) ovf <= 1'b1;
            else if (clr_ovf)               ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Self-checking bench for pdm_mic_rx: a cycle-indexed behavioural model
// (ock level from elapsed cycles, CIC output as a direct convolution with
// the order-3 boxcar impulse response) checked on every cycle, plus
// directed literal checks.
module tb_pdm_mic_rx;

    localparam int C    = 4;
    localparam int R    = 64;
    localparam int HLEN = 3 * R - 2;
    localparam int MAXP = 16384;
    localparam int FIRST_VALID = (2 * 4 * R + 1) * C + 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        sdi = 1'b0;
    logic        ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        ock, valid, ovf;
    logic [31:0] dout_l, dout_r;

    int checks = 0;
    int errors = 0;
    int mode = 0;

    pdm_mic_rx #(.CLKDIV(C), .DECIM(R)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .ock     (ock),
        .sdi     (sdi),
        .dout_l  (dout_l),
        .dout_r  (dout_r),
        .valid   (valid),
        .ready   (ready),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int h [HLEN];
    int xl [MAXP];
    int xr [MAXP];
    int m_t = 0;
    int m_pk = 0;
    int m_h2, m_p;
    bit m_pend = 0;
    bit m_ovf_evt;
    logic m_nv;
    logic exp_valid = 1'b0;
    logic exp_ovf = 1'b0;
    logic [31:0] exp_l = '0;
    logic [31:0] exp_r = '0;

    function automatic int cic_out(input int k, input bit left);
        int s = 0;
        for (int n = 0; n < HLEN; n++) begin
            int idx = k * R - n;
            if (idx >= 1) s += h[n] * (left ? xl[idx] : xr[idx]);
        end
        return s;
    endfunction

    initial begin
        for (int n = 0; n < HLEN; n++) h[n] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++) h[a + b + c]++;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_t = 0; m_pend = 0; exp_valid = 0; exp_ovf = 0; exp_l = '0; exp_r = '0;
        end else begin
            m_ovf_evt = 0;
            m_nv = exp_valid;
            if (exp_valid && ready) m_nv = 0;
            if (m_pend && m_pk >= 4) begin
                if (!exp_valid || ready) begin
                    exp_l = cic_out(m_pk, 1'b1);
                    exp_r = cic_out(m_pk, 1'b0);
                    m_nv = 1;
                end else begin
                    m_ovf_evt = 1;
                end
            end
            if (m_ovf_evt)    exp_ovf = 1;
            else if (clr_ovf) exp_ovf = 0;
            exp_valid = m_nv;
            m_pend = 0;
            if (!en) begin
                m_t = 0;
            end else begin
                m_t++;
                if (m_t % C == 0) begin
                    m_h2 = m_t / C;
                    if (m_h2 >= 2 && m_h2 % 2 == 0 && m_h2 / 2 < MAXP) begin
                        xl[m_h2 / 2] = sdi ? 1 : -1;
                    end else if (m_h2 >= 3 && m_h2 % 2 == 1 && (m_h2 - 1) / 2 < MAXP) begin
                        m_p = (m_h2 - 1) / 2;
                        xr[m_p] = sdi ? 1 : -1;
                        if (m_p % R == 0) begin
                            m_pend = 1;
                            m_pk = m_p / R;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ock", {31'd0, ock}, {31'd0, en && ((m_t / C) % 2 == 1)});
        chk("valid", {31'd0, valid}, {31'd0, exp_valid});
        chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        chk("dout_l", dout_l, exp_l);
        chk("dout_r", dout_r, exp_r);
    end

    // ---------------- sdi sources ----------------
    logic [31:0] macc = '0;
    logic [32:0] msum;
    logic        ock_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        case (mode)
            0: sdi = 1'($urandom % 2);
            1: sdi = 1'b1;
            2: sdi = ock;
            default: begin
                if (ock && !ock_prev) begin
                    msum = {1'b0, macc} + 33'h0_8000_0000;
                    macc = msum[31:0];
                    sdi  = msum[32];
                end
            end
        endcase
        ock_prev = ock;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            step();
            n++;
            if (valid) return;
        end
        n = -1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n, first_rise, second_rise, high_cnt;
        logic prev;
        logic [31:0] held_l;
        int sv;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        begin
            int hs = 0;
            for (int i = 0; i < HLEN; i++) hs += h[i];
            chk("model_h_sum", hs, 32'd262144);
        end
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_dout_l", dout_l, 32'd0);

        // ock timing and constant-1 input
        mode = 1; ready = 1'b0;
        step();
        en = 1'b1;
        first_rise = 0; second_rise = 0; high_cnt = 0; prev = 1'b0;
        n = 0;
        while (n < 3000) begin
            step();
            n++;
            if (ock && !prev) begin
                if (first_rise == 0) first_rise = n;
                else if (second_rise == 0) second_rise = n;
            end
            if (first_rise != 0 && second_rise == 0 && ock) high_cnt++;
            prev = ock;
            if (valid) break;
        end
        chk("ock_first_rise", first_rise, 32'd4);
        chk("ock_period", second_rise - first_rise, 32'd8);
        chk("ock_high_cycles", high_cnt, 32'd4);
        chk("first_valid_cycle", n, FIRST_VALID);
        chk("ones_dout_l", dout_l, 32'd262144);
        chk("ones_dout_r", dout_r, 32'd262144);

        // overflow while stalled
        held_l = dout_l;
        repeat (2 * 2 * C * R + 10) step();
        chk("ovf_hold_dout", dout_l, held_l);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        ready = 1'b1;
        repeat (20) step();

        // sdi follows ock: left all ones, right all zeros
        en = 1'b0;
        repeat (3) step();
        mode = 2;
        en = 1'b1;
        wait_valid(3000, n);
        chk("stereo_first_valid", n, FIRST_VALID);
        chk("stereo_dout_l", dout_l, 32'd262144);
        chk("stereo_dout_r", dout_r, 32'hFFFC_0000);

        // async reset mid-period
        repeat (300) step();
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_ock", {31'd0, ock}, 32'd0);
        chk("arst_dout_r", dout_r, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        wait_valid(3000, n);
        chk("restart_first_valid", n, FIRST_VALID);
        chk("restart_dout_r", dout_r, 32'hFFFC_0000);

        // midscale modulator loopback
        en = 1'b0;
        repeat (2) step();
        mode = 3;
        en = 1'b1;
        wait_valid(3000, n);
        sv = $signed(dout_l);
        chk("loop_small_first", {31'd0, (sv < 4096 && sv > -4096)}, 32'd1);
        repeat (1100) step();
        ready = 1'b0;
        wait_valid(1200, n);
        sv = $signed(dout_l);
        chk("loop_small_later", {31'd0, (sv < 4096 && sv > -4096)}, 32'd1);
        chk("loop_wait", {31'd0, n > 0}, 32'd1);

        // randomized traffic
        mode = 0;
        for (int seg = 0; seg < 24; seg++) begin
            int rp;
            rp = $urandom_range(0, 4);
            repeat (2 * C * R) begin
                ready   = ($urandom % 4) < rp;
                clr_ovf = ($urandom % 64) == 0;
                if ($urandom % 1500 == 0) begin
                    en = 1'b0;
                    repeat ($urandom_range(1, 30)) step();
                    en = 1'b1;
                end
                step();
            end
        end
        ready = 1'b1;
        clr_ovf = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
